// File: rtl/mprj_cfg_pkg.sv
// Shared types and constants for the user-pad configuration loader.
package mprj_cfg_pkg;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LOAD,
      DONE
   } state_e;

   // Power-on configuration word applied to every pad shadow.
   localparam logic [12:0] CFG_DEFAULT_WORD = 13'h0403;

endpackage : mprj_cfg_pkg

// File: rtl/mprj_cfg_shifter.sv
// Serial chain datapath: snapshot shift register, bit counter and the
// serial_clock half-period divider.
module mprj_cfg_shifter #(
   parameter  int unsigned NUM_PADS = 38,
   parameter  int unsigned CFG_W    = 13,
   parameter  int unsigned CLK_DIV  = 2,
   localparam int unsigned TOTAL    = NUM_PADS * CFG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_en,    // capture load_data, restart bit count
   input  logic [TOTAL-1:0] load_data,
   input  logic             run,        // FSM is in a timed phase
   input  logic             shift_en,   // advance to the next chain bit
   output logic             div_last,   // last cycle of the current phase
   output logic             last_bit,   // the bit on the line is the final one
   output logic             next_bit    // chain bit valid from the next cycle
);

   // Bit counter reaches TOTAL after the final shift, so it needs one more code.
   localparam int unsigned BIT_W = $clog2(TOTAL + 1);
   localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

   logic [TOTAL-1:0] shift_q, shift_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;

   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
   assign last_bit = (bit_q == BIT_W'(TOTAL - 1));
   assign next_bit = shift_d[TOTAL-1];

   // Next-state for the shift register and both counters.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      shift_d = shift_q;
      bit_d   = bit_q;
      if (load_en) begin
         shift_d = load_data;
         bit_d   = '0;
      end else if (shift_en) begin
         shift_d = {shift_q[TOTAL-2:0], 1'b0};
         bit_d   = bit_q + BIT_W'(1);
      end
      div_d = (run && !div_last) ? div_q + DIV_W'(1) : '0;
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_q <= '0;
         bit_q   <= '0;
         div_q   <= '0;
      end else begin
         shift_q <= shift_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
      end
   end

endmodule : mprj_cfg_shifter

// File: rtl/mprj_cfg_loader.sv
// User-pad configuration loader: per-pad shadow words written over a
// valid/ready port, shifted out serially on demand and latched with a strobe.
module mprj_cfg_loader
   import mprj_cfg_pkg::*;
#(
   parameter  int unsigned      NUM_PADS    = 38,
   parameter  int unsigned      CFG_W       = 13,
   parameter  int unsigned      CLK_DIV     = 2,
   parameter  logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(CFG_DEFAULT_WORD),
   parameter  bit               AUTO_APPLY  = 1'b1,
   localparam int unsigned      IDX_W       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             por_ok,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [CFG_W-1:0] cfg_data,
   output logic             cfg_err,
   input  logic             apply,
   output logic             busy,
   output logic             done,
   output logic             serial_clock,
   output logic             serial_data,
   output logic             serial_load
);

   localparam int unsigned TOTAL = NUM_PADS * CFG_W;

   state_e           state_q, state_d;
   logic             auto_q, auto_d;
   logic [CFG_W-1:0] shadow_q [NUM_PADS];
   logic [CFG_W-1:0] shadow_d [NUM_PADS];
   logic [TOTAL-1:0] snapshot;

   logic cfg_ready_q, cfg_ready_d;
   logic cfg_err_q, cfg_err_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic sclk_q, sclk_d;
   logic sdata_q, sdata_d;
   logic sload_q, sload_d;

   logic wr_en, idx_oor, start, run, shift_en;
   logic div_last, last_bit, next_bit;

   // Shadow write path; the updated words also feed the snapshot so a write
   // accepted on the start edge is part of the load.
   always_comb begin
      wr_en   = cfg_valid && cfg_ready_q;
      idx_oor = (32'(cfg_idx) >= NUM_PADS);
      shadow_d = shadow_q;
      if (wr_en && !idx_oor) shadow_d[cfg_idx] = cfg_data;
      snapshot = '0;
      for (int p = 0; p < int'(NUM_PADS); p++) snapshot[p*CFG_W +: CFG_W] = shadow_d[p];
   end

   // Sequencer next state; a pending auto-start is consumed by the first load.
   always_comb begin
      state_d = state_q;
      auto_d  = auto_q;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((apply || auto_q) && por_ok) begin
               state_d = SHIFT_LO;
               auto_d  = 1'b0;
               start   = 1'b1;
            end
         end
         SHIFT_LO: if (div_last) state_d = SHIFT_HI;
         SHIFT_HI: if (div_last) state_d = last_bit ? LOAD : SHIFT_LO;
         LOAD:     if (div_last) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   assign run      = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
   assign shift_en = (state_q == SHIFT_HI) && div_last;

   // Outputs are decoded from the next state so their registers track the FSM cycle-exactly.
   always_comb begin
      cfg_ready_d = (state_d == IDLE);
      cfg_err_d   = wr_en && idx_oor;
      busy_d      = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LOAD);
      done_d      = (state_d == DONE);
      sclk_d      = (state_d == SHIFT_HI);
      sdata_d     = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? next_bit : 1'b0;
      sload_d     = (state_d == LOAD);
   end

   // State, shadows and registered outputs.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         auto_q  <= AUTO_APPLY;
         // NOTE: the shadows are reset on purpose; CFG_DEFAULT is the pads' power-on configuration.
         for (int i = 0; i < int'(NUM_PADS); i++) shadow_q[i] <= CFG_DEFAULT;
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sclk_q      <= 1'b0;
         sdata_q     <= 1'b0;
         sload_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         auto_q      <= auto_d;
         shadow_q    <= shadow_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sclk_q      <= sclk_d;
         sdata_q     <= sdata_d;
         sload_q     <= sload_d;
      end
   end

   mprj_cfg_shifter #(
      .NUM_PADS (NUM_PADS),
      .CFG_W    (CFG_W),
      .CLK_DIV  (CLK_DIV)
   ) u_shifter (
      .clock     (clock),
      .reset     (reset),
      .load_en   (start),
      .load_data (snapshot),
      .run       (run),
      .shift_en  (shift_en),
      .div_last  (div_last),
      .last_bit  (last_bit),
      .next_bit  (next_bit)
   );

   assign cfg_ready    = cfg_ready_q;
   assign cfg_err      = cfg_err_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign serial_clock = sclk_q;
   assign serial_data  = sdata_q;
   assign serial_load  = sload_q;

endmodule : mprj_cfg_loader
